// File: rtl/mem_access_unit.sv
// Load/store unit that turns byte/half/word/dword requests into one or two
// lane-masked bus beats, splitting accesses that straddle a bus word.
module mem_access_unit #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_zext,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW/8-1:0] bus_be,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int BW = 2 * NB;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state, state_next;

    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          zext_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rd_low_q;

    logic [OW-1:0] req_off;
    logic [3:0]    req_bytes;
    logic          req_misalign;
    logic          req_error;
    logic          accept;

    logic [OW-1:0] off_q;
    logic [3:0]    bytes_q;
    logic [BW-1:0] be_wide;
    logic [NB-1:0] be0, be1;
    logic          crossing;
    logic [DW-1:0] mask0, mask1;
    logic [OW+2:0] sh0;
    logic [OW+3:0] sh1;
    logic [AW-1:0] base_addr;

    // Widens the assembled little-endian value from its top valid byte.
    function automatic logic [DW-1:0] extend_data(input logic [DW-1:0] v,
                                                  input logic [1:0] size,
                                                  input logic zext);
        logic [DW-1:0] r;
        int            nbytes;
        logic          sign;
        nbytes = 1 << size;
        if (nbytes > NB) nbytes = NB;
        sign = v[nbytes*8-1];
        r = v;
        for (int b = 0; b < NB; b++)
            if (b >= nbytes) r[b*8 +: 8] = zext ? 8'h00 : {8{sign}};
        return r;
    endfunction

    always_comb begin
        req_off      = req_addr[OW-1:0];
        req_bytes    = 4'd1 << req_size;
        req_misalign = |({{(4-OW){1'b0}}, req_off} & (req_bytes - 4'd1));
        req_error    = (req_size == 2'd3 && NB < 8) ||
                       (req_misalign && ALLOW_MISALIGN == 0);
        accept       = req_valid && req_ready;
    end

    // Lane enables for both beats come from one double-width mask shifted by the offset.
    always_comb begin
        off_q     = addr_q[OW-1:0];
        bytes_q   = 4'd1 << size_q;
        be_wide   = ((BW'(1) << bytes_q) - BW'(1)) << off_q;
        be0       = be_wide[NB-1:0];
        be1       = be_wide[BW-1:NB];
        crossing  = |be1;
        sh0       = {off_q, 3'b000};
        sh1       = (OW+4)'(DW) - (OW+4)'(sh0);
        base_addr = {addr_q[AW-1:OW], {OW{1'b0}}};
        mask0     = '0;
        mask1     = '0;
        for (int b = 0; b < NB; b++) begin
            mask0[b*8 +: 8] = {8{be0[b]}};
            mask1[b*8 +: 8] = {8{be1[b]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bus_valid  = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = '0;
        bus_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (accept) state_next = req_error ? RESP : BEAT0;
            end
            BEAT0: begin
                bus_valid = 1'b1;
                bus_we    = write_q;
                bus_addr  = base_addr;
                bus_be    = be0;
                bus_wdata = (wdata_q << sh0) & mask0;
                if (bus_ready) state_next = crossing ? BEAT1 : RESP;
            end
            BEAT1: begin
                bus_valid = 1'b1;
                bus_we    = write_q;
                bus_addr  = base_addr + AW'(NB);
                bus_be    = be1;
                bus_wdata = (wdata_q >> sh1) & mask1;
                if (bus_ready) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, read assembly and the held response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            zext_q     <= 1'b0;
            wdata_q    <= '0;
            rd_low_q   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q     <= req_addr;
                    size_q     <= req_size;
                    write_q    <= req_write;
                    zext_q     <= req_zext;
                    wdata_q    <= req_wdata;
                    resp_err   <= req_error;
                    resp_rdata <= '0;
                end
                BEAT0: if (bus_ready) begin
                    rd_low_q <= bus_rdata >> sh0;
                    if (!crossing)
                        resp_rdata <= write_q ? '0 :
                                      extend_data(bus_rdata >> sh0, size_q, zext_q);
                end
                BEAT1: if (bus_ready) begin
                    resp_rdata <= write_q ? '0 :
                                  extend_data(rd_low_q | (bus_rdata << sh1), size_q, zext_q);
                end
                RESP: if (resp_ready) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DW=32): a misalign-splitting instance
// and a strict instance that rejects misaligned accesses.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_valid_s;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_zext;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        req_ready, resp_valid, resp_err, bus_valid, bus_we;
    logic [31:0] resp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        s_req_ready, s_resp_valid, s_resp_err, s_bus_valid, s_bus_we;
    logic [31:0] s_resp_rdata, s_bus_addr, s_bus_wdata;
    logic [3:0]  s_bus_be;

    int checks = 0;
    int failures = 0;

    int          n_beats;
    int          resp_cycle;
    logic [31:0] beat_addr [2];
    logic [3:0]  beat_be [2];
    logic [31:0] beat_wdata [2];
    logic        beat_we [2];
    logic [31:0] got_rdata;
    logic        got_err;

    mem_access_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_zext(req_zext),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    mem_access_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(0)) dut_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s), .req_ready(s_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_zext(req_zext),
        .req_wdata(req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .bus_valid(s_bus_valid), .bus_ready(bus_ready), .bus_we(s_bus_we),
        .bus_addr(s_bus_addr), .bus_be(s_bus_be), .bus_wdata(s_bus_wdata),
        .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one request on the splitting instance and records every beat and the response.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic zext,
                                 input logic [31:0] wdata,
                                 input logic [31:0] rd0, input logic [31:0] rd1);
        n_beats    = 0;
        resp_cycle = -1;
        got_rdata  = 'x;
        got_err    = 1'bx;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = size;
        req_zext  = zext;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && resp_cycle < 0; cyc++) begin
            @(negedge clk);
            bus_rdata = (n_beats == 0) ? rd0 : rd1;
            if (bus_valid && bus_ready && n_beats < 2) begin
                beat_addr[n_beats]  = bus_addr;
                beat_be[n_beats]    = bus_be;
                beat_wdata[n_beats] = bus_wdata;
                beat_we[n_beats]    = bus_we;
                n_beats++;
            end
            if (resp_valid && resp_ready) begin
                got_rdata  = resp_rdata;
                got_err    = resp_err;
                resp_cycle = cyc;
            end
        end
        if (resp_cycle < 0) checkOutput("resp_timeout", 64'(resp_cycle), 64'd1);
    endtask

    int stable;
    int completions;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_valid_s = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_size    = '0;
        req_zext    = 1'b0;
        req_wdata   = '0;
        resp_ready  = 1'b1;
        bus_ready   = 1'b1;
        bus_rdata   = '0;

        #3;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_bus_valid", 64'(bus_valid), 64'd0);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_resp_rdata", 64'(resp_rdata), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);

        // Aligned word load.
        applyStimulus(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);
        checkOutput("lw_beats", 64'(n_beats), 64'd1);
        checkOutput("lw_addr", 64'(beat_addr[0]), 64'h100);
        checkOutput("lw_be", 64'(beat_be[0]), 64'hF);
        checkOutput("lw_we", 64'(beat_we[0]), 64'd0);
        checkOutput("lw_rdata", 64'(got_rdata), 64'hDEADBEEF);
        checkOutput("lw_err", 64'(got_err), 64'd0);
        checkOutput("lw_latency", 64'(resp_cycle), 64'd2);

        // Byte load from the top lane, signed then unsigned.
        applyStimulus(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'h80A1B2C3, 32'h0);
        checkOutput("lb_be", 64'(beat_be[0]), 64'h8);
        checkOutput("lb_sext", 64'(got_rdata), 64'hFFFFFF80);
        applyStimulus(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 32'h80A1B2C3, 32'h0);
        checkOutput("lbu_zext", 64'(got_rdata), 64'h00000080);

        // Aligned half load from the upper half.
        applyStimulus(1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 32'h8001AAAA, 32'h0);
        checkOutput("lh_be", 64'(beat_be[0]), 64'hC);
        checkOutput("lh_sext", 64'(got_rdata), 64'hFFFF8001);

        // Misaligned word store split across two bus words.
        applyStimulus(1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344, 32'h0, 32'h0);
        checkOutput("sw_beats", 64'(n_beats), 64'd2);
        checkOutput("sw_b0_addr", 64'(beat_addr[0]), 64'h100);
        checkOutput("sw_b0_be", 64'(beat_be[0]), 64'hC);
        checkOutput("sw_b0_wdata", 64'(beat_wdata[0]), 64'h33440000);
        checkOutput("sw_b0_we", 64'(beat_we[0]), 64'd1);
        checkOutput("sw_b1_addr", 64'(beat_addr[1]), 64'h104);
        checkOutput("sw_b1_be", 64'(beat_be[1]), 64'h3);
        checkOutput("sw_b1_wdata", 64'(beat_wdata[1]), 64'h00001122);
        checkOutput("sw_rdata", 64'(got_rdata), 64'h0);
        checkOutput("sw_latency", 64'(resp_cycle), 64'd3);

        // Split half load: lane 3 of beat 0 is the low byte, lane 0 of beat 1 the high byte.
        applyStimulus(1'b0, 32'h103, 2'd1, 1'b0, 32'h0, 32'hAB000000, 32'h556677CD);
        checkOutput("lh_split_b0_be", 64'(beat_be[0]), 64'h8);
        checkOutput("lh_split_b1_be", 64'(beat_be[1]), 64'h1);
        checkOutput("lh_split_rdata", 64'(got_rdata), 64'hFFFFCDAB);

        // Address wrap on the second beat.
        applyStimulus(1'b0, 32'hFFFFFFFF, 2'd1, 1'b0, 32'h0, 32'h12000000, 32'h00000034);
        checkOutput("wrap_b0_addr", 64'(beat_addr[0]), 64'hFFFFFFFC);
        checkOutput("wrap_b1_addr", 64'(beat_addr[1]), 64'h0);
        checkOutput("wrap_rdata", 64'(got_rdata), 64'h00003412);
        checkOutput("wrap_err", 64'(got_err), 64'd0);

        // Doubleword on a 32-bit bus is rejected without touching the bus.
        applyStimulus(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0);
        checkOutput("sd_beats", 64'(n_beats), 64'd0);
        checkOutput("sd_err", 64'(got_err), 64'd1);
        checkOutput("sd_rdata", 64'(got_rdata), 64'h0);
        checkOutput("sd_latency", 64'(resp_cycle), 64'd1);

        // Bus stall in BEAT0 then response stall.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h200;
        req_size   = 2'd2;
        req_zext   = 1'b0;
        bus_ready  = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_valid && bus_addr == 32'h200 && bus_be == 4'hF && !bus_we) stable++;
        end
        checkOutput("stall_bus_stable", 64'(stable), 64'd3);
        @(negedge clk);
        checkOutput("stall_bus_valid", 64'(bus_valid), 64'd1);
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        stable = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid && resp_rdata == 32'hCAFEF00D && !resp_err && !req_ready && !bus_valid)
                stable++;
        end
        checkOutput("stall_resp_stable", 64'(stable), 64'd2);
        @(negedge clk);
        resp_ready = 1'b1;
        completions = resp_valid ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) completions++;
        end
        checkOutput("stall_completions", 64'(completions), 64'd1);
        checkOutput("stall_idle_ready", 64'(req_ready), 64'd1);

        // Reset asserted while the second beat of a split store is pending.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h102;
        req_size  = 2'd2;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 bus_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_b1_addr", 64'(bus_addr), 64'h104);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_bus_valid", 64'(bus_valid), 64'd0);
        checkOutput("rst_async_bus_be", 64'(bus_be), 64'd0);
        checkOutput("rst_async_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("rst_release_req_ready", 64'(req_ready), 64'd1);
        completions = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid || bus_valid) completions++;
        end
        checkOutput("rst_discarded", 64'(completions), 64'd0);

        // Strict instance rejects a misaligned half load.
        @(negedge clk);
        req_valid_s = 1'b1;
        req_write   = 1'b0;
        req_addr    = 32'h103;
        req_size    = 2'd1;
        checkOutput("strict_req_ready", 64'(s_req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid_s = 1'b0;
        @(negedge clk);
        checkOutput("strict_resp_valid", 64'(s_resp_valid), 64'd1);
        checkOutput("strict_resp_err", 64'(s_resp_err), 64'd1);
        checkOutput("strict_resp_rdata", 64'(s_resp_rdata), 64'h0);
        checkOutput("strict_bus_valid", 64'(s_bus_valid), 64'd0);
        @(negedge clk);
        checkOutput("strict_back_idle", 64'(s_req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
